dmem_lsu: RTL

Load/store access unit sitting between the MEM stage of the 5-stage RV32I core and the data-memory dual-port RAM. It accepts one byte/half/word load or store at a time, drives the RAM's write and read ports, and returns sign- or zero-extended load data. The RAM has no byte enables, so the unit implements sub-word stores as read-modify-write. It also flags misaligned accesses.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lsu_lane_align.sv | 42 ++++
 rtl/dmem_lsu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory load/store unit.
// Size encodings, FSM states and the data word width.
package dmem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RMW  = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Lane alignment: load extract/extend and store merge into old word.
// Purely combinational; offsets arrive already naturally aligned.
module lsu_lane_align
  import dmem_pkg::*;
(
  input  size_e            size_i,
  input  logic [1:0]       off_i,
  input  logic             uns_i,
  input  logic [XLEN-1:0]  old_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic [XLEN-1:0]  ld_o,
  output logic [XLEN-1:0]  st_o
);

  logic [4:0]      sh;
  logic [XLEN-1:0] shifted;

  assign sh      = {off_i, 3'b000};
  assign shifted = old_i >> sh;

  always_comb begin
    ld_o = old_i;
    st_o = wdata_i;
    unique case (1'b1)
      (size_i == SZ_B): begin
        ld_o = {{24{!uns_i && shifted[7]}}, shifted[7:0]};
        st_o = (old_i & ~(32'h0000_00FF << sh))
             | ({24'b0, wdata_i[7:0]} << sh);
      end
      (size_i == SZ_H): begin
        ld_o = {{16{!uns_i && shifted[15]}}, shifted[15:0]};
        st_o = (old_i & ~(32'h0000_FFFF << sh))
             | ({16'b0, wdata_i[15:0]} << sh);
      end
      default: begin
        ld_o = old_i;
        st_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-enable-less dual-port RAM.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned/illegal requests.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err,
  output logic            ram_wr_en,
  output logic [AW-1:0]   ram_wr_addr,
  output logic [31:0]     ram_wr_data,
  output logic            ram_rd_en,
  output logic [AW-1:0]   ram_rd_addr,
  input  logic [31:0]     ram_rd_data
);

  state_e          state_q, state_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [1:0]      off_q, off_d;
  size_e           size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rvld_q, rvld_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rerr_q, rerr_d;

  logic            accept, bad, wr_c, rd_c;
  size_e           sz_in, sz_eff;
  logic [1:0]      off_in;
  logic [AW-1:0]   req_waddr;
  logic [31:0]     ld_data, st_word;
  logic            unused_addr;

  assign sz_in       = size_e'(req_size);
  assign req_waddr   = req_addr[AW+1:2];
  assign unused_addr = ^req_addr[31:AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign sz_eff = sz_in;
  assign off_in = req_addr[1:0];
  assign bad    = (sz_in == SZ_X)
               || (sz_in == SZ_H && req_addr[0])
               || (sz_in == SZ_W && req_addr[1:0] != 2'b00);
`else
  assign sz_eff = (sz_in == SZ_X) ? SZ_W : sz_in;
  assign off_in = (sz_eff == SZ_B) ? req_addr[1:0]
                : (sz_eff == SZ_H) ? {req_addr[1], 1'b0}
                : 2'b00;
  assign bad    = 1'b0;
`endif

  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  lsu_lane_align u_align (
    .size_i  (size_q),
    .off_i   (off_q),
    .uns_i   (uns_q),
    .old_i   (ram_rd_data),
    .wdata_i (wdata_q),
    .ld_o    (ld_data),
    .st_o    (st_word)
  );

  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rvld_d      = 1'b0;
    rdata_d     = '0;
    rerr_d      = 1'b0;
    wr_c        = 1'b0;
    rd_c        = 1'b0;
    ram_wr_addr = req_waddr;
    ram_wr_data = req_wdata;
    ram_rd_addr = req_waddr;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            rvld_d = 1'b1;
            rerr_d = 1'b1;
          end else if (req_we && sz_eff == SZ_W) begin
            wr_c   = 1'b1;
            rvld_d = 1'b1;
          end else begin
            rd_c    = 1'b1;
            waddr_d = req_waddr;
            off_d   = off_in;
            size_d  = sz_eff;
            uns_d   = req_unsigned;
            wdata_d = req_wdata;
            state_d = req_we ? RMW : LOAD;
          end
        end
      end
      LOAD: begin
        rvld_d  = 1'b1;
        rdata_d = ld_data;
        state_d = IDLE;
      end
      RMW: begin
        wr_c        = 1'b1;
        ram_wr_addr = waddr_q;
        ram_wr_data = st_word;
        rvld_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must also kill an in-flight RMW write, not just the state.
  assign ram_wr_en = wr_c && !rst;
  assign ram_rd_en = rd_c && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      waddr_q <= '0;
      off_q   <= '0;
      size_q  <= SZ_W;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  assign rsp_valid = rvld_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;

endmodule
